// File: rtl/vend_pkg.sv
// Shared vending-machine types: coin encodings, coin values and the payment FSM states.
package vend_pkg;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;
    localparam int unsigned VAL_25 = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        CHANGE  = 2'd2
    } pay_state_t;

    // Value in cents of an encoded coin; the invalid encoding is worth nothing.
    function automatic logic [4:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_5:  return 5'(VAL_5);
            COIN_10: return 5'(VAL_10);
            COIN_25: return 5'(VAL_25);
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_gen.sv
// Combinational greedy change selector: largest coin that does not exceed the remaining credit.
module change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [1:0]          o_coin,
    output logic [CREDIT_W-1:0] o_value
);

    always_comb begin
        o_coin  = COIN_5;
        o_value = CREDIT_W'(VAL_5);
        if (i_credit >= CREDIT_W'(VAL_25)) begin
            o_coin  = COIN_25;
            o_value = CREDIT_W'(VAL_25);
        end else if (i_credit >= CREDIT_W'(VAL_10)) begin
            o_coin  = COIN_10;
            o_value = CREDIT_W'(VAL_10);
        end
    end

endmodule

// File: rtl/payment_ctrl.sv
// Vending payment controller: credit accumulation, dispense handshake, change/refund.
// Optional dispense-wait timeout with timeout_err output when PAYMENT_TIMEOUT_EN is defined.
module payment_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
`ifdef PAYMENT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    input  logic                cancel,
    input  logic                dispense,
    output logic                dispense_req,
    output logic                payment_ok,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                busy
`ifdef PAYMENT_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    localparam int SUM_W = CREDIT_W + 1;

    pay_state_t          r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_price, w_price_nxt;
    logic                r_req, w_req_nxt;
    logic                r_coin_rej, w_coin_rej_nxt;
    logic                r_sel_rej, w_sel_rej_nxt;
    logic                r_chg_valid, w_chg_valid_nxt;
    logic [1:0]          r_chg_coin, w_chg_coin_nxt;
    logic                r_busy;

    logic [1:0]          w_gen_coin;
    logic [CREDIT_W-1:0] w_gen_value;
    logic [SUM_W-1:0]    w_coin_sum;
    logic                w_coin_fits;

`ifdef PAYMENT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic             r_tmo_err, w_tmo_err_nxt;
`endif

    change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .i_credit (r_credit),
        .o_coin   (w_gen_coin),
        .o_value  (w_gen_value)
    );

    // Sum is one bit wider so an overflowing coin is detected rather than wrapped.
    assign w_coin_sum  = {1'b0, r_credit} + SUM_W'(coin_value(coin_val));
    assign w_coin_fits = (coin_val != COIN_BAD) && (w_coin_sum <= SUM_W'(MAX_CREDIT));

    always_comb begin
        w_state_nxt     = r_state;
        w_credit_nxt    = r_credit;
        w_price_nxt     = r_price;
        w_req_nxt       = 1'b0;
        w_coin_rej_nxt  = 1'b0;
        w_sel_rej_nxt   = 1'b0;
        w_chg_valid_nxt = 1'b0;
        w_chg_coin_nxt  = 2'b00;
`ifdef PAYMENT_TIMEOUT_EN
        w_tmo_cnt_nxt   = '0;
        w_tmo_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (cancel) begin
                    w_coin_rej_nxt = coin_valid;
                    if (r_credit != '0) w_state_nxt = CHANGE;
                end else begin
                    if (coin_valid) begin
                        if (w_coin_fits) w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                        else             w_coin_rej_nxt = 1'b1;
                    end
                    // Selection is judged against the credit before any same-cycle coin.
                    if (sel_valid) begin
                        if (r_credit >= sel_price) begin
                            w_price_nxt = sel_price;
                            w_req_nxt   = 1'b1;
                            w_state_nxt = REQUEST;
                        end else begin
                            w_sel_rej_nxt = 1'b1;
                        end
                    end
                end
            end
            REQUEST: begin
                w_coin_rej_nxt = coin_valid;
                if (dispense) begin
                    w_credit_nxt = r_credit - r_price;
                    w_state_nxt  = (r_credit == r_price) ? IDLE : CHANGE;
`ifdef PAYMENT_TIMEOUT_EN
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = (r_credit != '0) ? CHANGE : IDLE;
                end else begin
                    w_req_nxt     = 1'b1;
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
`else
                end else begin
                    w_req_nxt = 1'b1;
                end
`endif
            end
            CHANGE: begin
                w_coin_rej_nxt = coin_valid;
                if (r_credit == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_chg_valid_nxt = 1'b1;
                    w_chg_coin_nxt  = w_gen_coin;
                    w_credit_nxt    = r_credit - w_gen_value;
                    if (r_credit == w_gen_value) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_price     <= '0;
            r_req       <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_sel_rej   <= 1'b0;
            r_chg_valid <= 1'b0;
            r_chg_coin  <= 2'b00;
            r_busy      <= 1'b0;
`ifdef PAYMENT_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_tmo_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_price     <= w_price_nxt;
            r_req       <= w_req_nxt;
            r_coin_rej  <= w_coin_rej_nxt;
            r_sel_rej   <= w_sel_rej_nxt;
            r_chg_valid <= w_chg_valid_nxt;
            r_chg_coin  <= w_chg_coin_nxt;
            r_busy      <= (w_state_nxt != IDLE);
`ifdef PAYMENT_TIMEOUT_EN
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_tmo_err   <= w_tmo_err_nxt;
`endif
        end
    end

    assign dispense_req = r_req;
    assign payment_ok   = r_req;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_rej;
    assign sel_reject   = r_sel_rej;
    assign change_valid = r_chg_valid;
    assign change_coin  = r_chg_coin;
    assign busy         = r_busy;
`ifdef PAYMENT_TIMEOUT_EN
    assign timeout_err  = r_tmo_err;
`endif

endmodule

// File: tb/tb_payment_ctrl.sv
// Self-checking bench for payment_ctrl: directed vectors, event scoreboard, registered dispenser model.
// Timeout scenario is exercised when PAYMENT_TIMEOUT_EN is defined.
module tb_payment_ctrl;

    localparam int CW = 8;
    localparam logic [2:0] EV_CHG  = 3'd1;
    localparam logic [2:0] EV_CREJ = 3'd2;
    localparam logic [2:0] EV_SREJ = 3'd3;
    localparam logic [2:0] EV_REQ  = 3'd4;
    localparam logic [2:0] EV_TMO  = 3'd5;
    localparam logic [1:0] C5 = 2'b00, C10 = 2'b01, C25 = 2'b10, CBAD = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_val = 2'b00;
    logic          sel_valid = 1'b0;
    logic [CW-1:0] sel_price = '0;
    logic          cancel = 1'b0;
    logic          dispense = 1'b0;
    logic          dis_en = 1'b1;
    logic          dispense_req, payment_ok, coin_reject, sel_reject, change_valid, busy;
    logic [CW-1:0] credit;
    logic [1:0]    change_coin;
`ifdef PAYMENT_TIMEOUT_EN
    logic          timeout_err;
`endif

    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    logic prev_req = 1'b0;

    payment_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel_valid    (sel_valid),
        .sel_price    (sel_price),
        .cancel       (cancel),
        .dispense     (dispense),
        .dispense_req (dispense_req),
        .payment_ok   (payment_ok),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sel_reject   (sel_reject),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .busy         (busy)
`ifdef PAYMENT_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    // ---------------- clock / reset / dispenser ----------------
    always #5 clk = ~clk;

    // Dispenser registers the request, so its confirmation lags by one cycle and is two cycles wide.
    always @(posedge clk) dispense <= rst ? 1'b0 : (dispense_req & dis_en);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic see_event(input logic [10:0] ev);
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got 0x%0h expected none at %0t", ev, $time);
        end else begin
            e = exp_q.pop_front();
            check("event", {21'd0, ev}, {21'd0, e});
        end
    endtask

    function automatic logic [10:0] ev_chg(input logic [1:0] c);
        return {EV_CHG, 6'd0, c};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (change_valid) see_event(ev_chg(change_coin));
            if (coin_reject)  see_event({EV_CREJ, 8'd0});
            if (sel_reject)   see_event({EV_SREJ, 8'd0});
            if (dispense_req && !prev_req) begin
                see_event({EV_REQ, credit});
                check("payment_ok", {31'd0, payment_ok}, 32'd1);
            end
`ifdef PAYMENT_TIMEOUT_EN
            if (timeout_err) see_event({EV_TMO, 8'd0});
`endif
            prev_req = dispense_req;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic cv, input logic [1:0] cval, input logic sv,
                         input logic [CW-1:0] price, input logic cn);
        @(negedge clk);
        coin_valid = cv; coin_val = cval; sel_valid = sv; sel_price = price; cancel = cn;
        @(negedge clk);
        coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0; sel_price = '0; cancel = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        drive(1'b1, c, 1'b0, '0, 1'b0);
    endtask

    task automatic select(input logic [CW-1:0] p);
        drive(1'b0, 2'b00, 1'b1, p, 1'b0);
    endtask

    task automatic do_cancel();
        drive(1'b0, 2'b00, 1'b0, '0, 1'b1);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        @(negedge clk);
        while (busy && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int hi;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_credit", {24'd0, credit}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req", {31'd0, dispense_req}, 32'd0);
        check("reset_ok", {31'd0, payment_ok}, 32'd0);
        check("reset_outs", {28'd0, change_valid, coin_reject, sel_reject, change_coin != 2'b00}, 32'd0);

        // purchase with change: 50 - 35 = 15 -> 10c, 5c
        coin(C25); coin(C25);
        check("credit_50", {24'd0, credit}, 32'd50);
        exp_q.push_back({EV_REQ, 8'd50});
        exp_q.push_back(ev_chg(C10));
        exp_q.push_back(ev_chg(C5));
        select(8'd35);
        check("req_latency", {31'd0, dispense_req}, 32'd1);
        check("ok_latency", {31'd0, payment_ok}, 32'd1);
        wait_idle();
        check("after_change_credit", {24'd0, credit}, 32'd0);

        // insufficient credit, then refund of the 10c
        coin(C10);
        exp_q.push_back({EV_SREJ, 8'd0});
        select(8'd35);
        check("insufficient_credit", {24'd0, credit}, 32'd10);
        check("insufficient_no_req", {31'd0, dispense_req}, 32'd0);
        exp_q.push_back(ev_chg(C10));
        do_cancel();
        wait_idle();

        // cancel refund of 40c
        coin(C25); coin(C10); coin(C5);
        check("credit_40", {24'd0, credit}, 32'd40);
        exp_q.push_back(ev_chg(C25));
        exp_q.push_back(ev_chg(C10));
        exp_q.push_back(ev_chg(C5));
        do_cancel();
        wait_idle();
        check("refund_credit", {24'd0, credit}, 32'd0);

        // cancel with zero credit is ignored
        do_cancel();
        check("cancel_zero_busy", {31'd0, busy}, 32'd0);

        // invalid coin in IDLE
        exp_q.push_back({EV_CREJ, 8'd0});
        coin(CBAD);
        check("bad_coin_credit", {24'd0, credit}, 32'd0);

        // coin during REQUEST, dispenser held off
        dis_en = 1'b0;
        coin(C25); coin(C25);
        exp_q.push_back({EV_REQ, 8'd50});
        select(8'd35);
        exp_q.push_back({EV_CREJ, 8'd0});
        coin(C10);
        check("request_coin_credit", {24'd0, credit}, 32'd50);
        check("request_held", {31'd0, dispense_req}, 32'd1);
        exp_q.push_back(ev_chg(C10));
        exp_q.push_back(ev_chg(C5));
        dis_en = 1'b1;
        wait_idle();

        // coin during CHANGE: 75c refunded, coin lands with the second change coin
        coin(C25); coin(C25); coin(C25);
        exp_q.push_back(ev_chg(C25));
        exp_q.push_back(ev_chg(C25));
        exp_q.push_back({EV_CREJ, 8'd0});
        exp_q.push_back(ev_chg(C25));
        do_cancel();
        coin(C10);
        wait_idle();
        check("change_coin_credit", {24'd0, credit}, 32'd0);

        // credit limit: 190 + 25 rejected, 190 + 10 = 200 accepted, 200 + 5 rejected
        repeat (7) coin(C25);
        coin(C10); coin(C5);
        check("credit_190", {24'd0, credit}, 32'd190);
        exp_q.push_back({EV_CREJ, 8'd0});
        coin(C25);
        check("overflow_25", {24'd0, credit}, 32'd190);
        coin(C10);
        check("exact_max", {24'd0, credit}, 32'd200);
        exp_q.push_back({EV_CREJ, 8'd0});
        coin(C5);
        check("overflow_5", {24'd0, credit}, 32'd200);
        // cancel beats a same-cycle coin, then 8 x 25c refund
        exp_q.push_back({EV_CREJ, 8'd0});
        repeat (8) exp_q.push_back(ev_chg(C25));
        drive(1'b1, C10, 1'b0, '0, 1'b1);
        wait_idle();
        check("max_refund_credit", {24'd0, credit}, 32'd0);

        // simultaneous select and coin: select sees pre-coin credit
        coin(C25); coin(C5);
        exp_q.push_back({EV_SREJ, 8'd0});
        drive(1'b1, C10, 1'b1, 8'd35, 1'b0);
        check("sim_coin_added", {24'd0, credit}, 32'd40);
        exp_q.push_back({EV_REQ, 8'd45});
        exp_q.push_back(ev_chg(C10));
        drive(1'b1, C5, 1'b1, 8'd35, 1'b0);
        wait_idle();
        check("sim_credit", {24'd0, credit}, 32'd0);

        // exact payment, trailing dispense must not deduct again
        coin(C25); coin(C25);
        exp_q.push_back({EV_REQ, 8'd50});
        select(8'd50);
        wait_idle();
        repeat (3) @(negedge clk);
        check("exact_credit", {24'd0, credit}, 32'd0);
        check("exact_busy", {31'd0, busy}, 32'd0);
        check("exact_req_low", {31'd0, dispense_req}, 32'd0);

`ifdef PAYMENT_TIMEOUT_EN
        // no dispense: request held 16 cycles, then full refund
        dis_en = 1'b0;
        coin(C25); coin(C25);
        exp_q.push_back({EV_REQ, 8'd50});
        exp_q.push_back({EV_TMO, 8'd0});
        exp_q.push_back(ev_chg(C25));
        exp_q.push_back(ev_chg(C25));
        select(8'd35);
        hi = 0;
        while (dispense_req && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_req_cycles", hi, 32'd16);
        wait_idle();
        check("timeout_credit", {24'd0, credit}, 32'd0);
        dis_en = 1'b1;
`endif

        // reset mid-transaction discards credit
        coin(C25);
        check("pre_reset_credit", {24'd0, credit}, 32'd25);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_discard", {24'd0, credit}, 32'd0);
        check("reset_no_refund", {31'd0, change_valid}, 32'd0);

        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/payment_ctrl.md
Name: payment_ctrl

Overview:
- Payment-side controller of the vending machine and initiator of the product-dispense handshake.
- Accumulates inserted coins into a credit, validates product selections against the price, and drives dispense_req/payment_ok to the product dispenser.
- On the dispenser's registered dispense confirmation, deducts the price and returns change one coin per cycle.
- Also handles cancel/refund.

Parameters:
- CREDIT_W, 8, width of credit and price in cents.
- MAX_CREDIT, 200, maximum credit in cents. Must be a multiple of 5 and no greater than 2^CREDIT_W-1.
- TIMEOUT_CYCLES, 16, dispense-wait limit. Used only with PAYMENT_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- coin_valid  in  1  one-cycle coin-inserted strobe
- coin_val  in  2  00=5c, 01=10c, 10=25c, 11=invalid
- sel_valid  in  1  one-cycle product-select strobe
- sel_price  in  CREDIT_W  price of the selected product, multiple of 5
- cancel  in  1  one-cycle refund request
- dispense  in  1  dispenser confirmation, registered on the dispenser side
- dispense_req  out  1  request product release
- payment_ok  out  1  payment confirmed
- credit  out  CREDIT_W  current credit in cents
- coin_reject  out  1  one-cycle pulse: coin returned uncounted
- sel_reject  out  1  one-cycle pulse: insufficient credit
- change_valid  out  1  one-cycle pulse per change coin
- change_coin  out  2  encoding as coin_val, valid with change_valid
- busy  out  1  high in REQUEST or CHANGE

Behaviour:
- All outputs are registered. Reset: state=IDLE, credit=0, all outputs 0. Reset mid-transaction discards credit with no refund.
- States: IDLE, REQUEST, CHANGE.
- IDLE, coin handling:
  - coin_valid with a legal coin and credit+value <= MAX_CREDIT: credit += value next cycle.
  - coin_val=11 or an overflowing coin: coin_reject=1 for one cycle, credit unchanged.
- IDLE, sel_valid:
  - If credit >= sel_price: latch the price and go to REQUEST.
  - Else: sel_reject pulse, stay in IDLE.
- IDLE, simultaneous events:
  - sel_valid and coin_valid in the same cycle: the selection compares against the pre-coin credit; the coin is still added.
  - cancel has priority over sel_valid and coin_valid. A coin in the same cycle as cancel is rejected.
- IDLE, cancel: credit>0 goes to CHANGE (full refund); credit=0 is ignored.
- REQUEST:
  - dispense_req=1 and payment_ok=1, asserted the cycle after the accepted sel_valid.
  - dispense is sampled only in this state. On dispense=1: credit -= latched price, both outputs drop next cycle, go to CHANGE (or IDLE if the remainder is 0).
  - Coins are rejected. cancel and sel_valid are ignored: the transaction is committed.
- Handshake latency: sel_valid at edge N, req high from N+1, dispense high from N+2, req low from N+3.
  - The dispenser's dispense is 2 cycles wide as a result. The trailing cycle arrives outside REQUEST and must be ignored.
- CHANGE:
  - One coin per cycle, greedy: 25c if credit>=25, else 10c if credit>=10, else 5c.
  - change_valid=1 with change_coin; credit decremented in the same registered update.
  - Returns to IDLE the cycle after credit reaches 0. Coins rejected, sel_valid/cancel ignored.
- Arithmetic: all values are multiples of 5, so no remainder is possible. credit never exceeds MAX_CREDIT and never underflows.
- busy = (state != IDLE).

Optional Feature:
- Macro: PAYMENT_TIMEOUT_EN.
- Defined:
  - A counter runs in REQUEST.
  - If dispense is not seen within TIMEOUT_CYCLES cycles of req assertion, req/payment_ok drop and the price is not deducted.
  - The FSM enters CHANGE to refund the full credit, and an extra output timeout_err pulses for one cycle.
- Undefined: REQUEST waits indefinitely; no counter and no timeout_err port.

Decomposition:
- Package vend_pkg:
  - coin encodings COIN_5/COIN_10/COIN_25/COIN_BAD
  - coin value constants (5, 10, 25)
  - state enum pay_state_t {IDLE, REQUEST, CHANGE}
  - a function coin_value(coin_val)
- One natural sub-module: change_gen, the combinational greedy selector. It takes credit and returns the next change_coin and its value; payment_ctrl registers the result.

Test Plan:
- Credit and change: reset, then 25c, 25c, then sel_price=35 -> credit=50, req/payment_ok high 1 cycle after sel; on dispense -> change 10c then 5c, credit 0, IDLE.
- Insufficient credit: 10c, then sel_price=35 -> sel_reject pulse, no dispense_req, credit stays 10.
- Cancel refund: 25c, 10c, 5c, then cancel -> change coins 25c, 10c, 5c on 3 consecutive cycles, then IDLE.
- Coins while busy and at the limit: coin during REQUEST and CHANGE -> coin_reject, credit unchanged; coin_val=11 in IDLE -> coin_reject; credit=190 plus 25c with MAX_CREDIT=200 -> coin_reject.
- Exact payment and late dispense: price equals credit (50) -> after dispense credit=0, direct to IDLE, no change_valid; trailing dispense cycle causes no second deduction.
- Timeout (PAYMENT_TIMEOUT_EN): hold dispense=0 after req -> req drops after 16 cycles, timeout_err pulse, full 50c refunded as 25c, 25c.
